ctrl_csr_bank: RTL and testbench

- Parametrised control/status register bank for the core's memory-mapped I/O control space.
- Replaces the fixed 4-entry control register file with:
  - N registers;
  - byte-strobed writes;
  - a valid/ready request/response handshake with registered read data;
  - hardware-side ports: sticky W1C status events, result-byte counting, a self-clearing GO pulse and a masked interrupt.
- Sits between the core's MMIO decode and the UART/loader control logic.

---
 rtl/ctrl_csr_bank_pkg.sv | 31 +++
 rtl/ctrl_csr_bank.sv | 136 +++++++++++++
 tb/tb_ctrl_csr_bank.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_csr_bank_pkg.sv
// Shared definitions for the control/status register bank: register indices,
// the GO bit position and the byte-strobe merge helper.
// The helper works on a fixed maximum width; callers zero-extend and truncate.
package csr_pkg;

  localparam int CSR_CTRL    = 0;
  localparam int CSR_STATUS  = 1;
  localparam int CSR_RESULT  = 2;
  localparam int CSR_IRQ_EN  = 3;

  localparam int CTRL_GO_BIT = 0;

  // Widest register the merge helper supports (256 bits, 32 byte lanes).
  localparam int CSR_MAX_W = 256;
  localparam int CSR_MAX_B = CSR_MAX_W / 8;

  // Replace byte k of old with byte k of wdata wherever wstrb[k] is set.
  function automatic logic [CSR_MAX_W-1:0] apply_wstrb(
    input logic [CSR_MAX_W-1:0] old,
    input logic [CSR_MAX_W-1:0] wdata,
    input logic [CSR_MAX_B-1:0] wstrb
  );
    logic [CSR_MAX_W-1:0] res;
    res = old;
    for (int k = 0; k < CSR_MAX_B; k++) begin
      if (wstrb[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ctrl_csr_bank.sv
// Control/status register bank: N byte-strobed registers behind a valid/ready
// request/response port, with W1C status events, a byte counter, a GO pulse and irq.
// One registered response per accepted request; requests stall while a response waits.
module ctrl_csr_bank
  import csr_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  input  logic [DATA_W-1:0]   hw_event,
  input  logic                hw_inc,
  output logic                start_pulse,
  output logic [DATA_W-1:0]   status,
  output logic [DATA_W-1:0]   result_bytes,
  output logic                irq
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [ADDR_W-1:0] IDX_CTRL   = ADDR_W'(CSR_CTRL);
  localparam logic [ADDR_W-1:0] IDX_STATUS = ADDR_W'(CSR_STATUS);
  localparam logic [ADDR_W-1:0] IDX_RESULT = ADDR_W'(CSR_RESULT);
  localparam logic [ADDR_W-1:0] IDX_IRQ_EN = ADDR_W'(CSR_IRQ_EN);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic              start_pulse_q;
  logic              start_pulse_d;

  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              wr_en;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] status_clr;
  logic              result_wr;
  logic [DATA_W-1:0] rdata_d;

  // A new request may enter whenever the response slot is empty or draining.
  assign req_ready = !resp_valid_q || resp_ready;
  assign accept    = req_valid && req_ready;

  // The full 32-bit compare rejects both high indices and nonzero upper bits.
  assign in_range = (req_addr < 32'(NUM_REGS));
  assign idx      = req_addr[ADDR_W-1:0];
  assign wr_en    = accept && req_we && in_range;

  assign merged = DATA_W'(apply_wstrb(CSR_MAX_W'(regs_q[idx]),
                                      CSR_MAX_W'(req_wdata),
                                      CSR_MAX_B'(req_wstrb)));

  // Read data is the pre-update register value; GO is never stored, so reads 0.
  assign rdata_d = (in_range && !req_we) ? regs_q[idx] : '0;

  // Next register contents from the bus write and the hardware-side inputs.
  always_comb begin
    regs_d        = regs_q;
    start_pulse_d = 1'b0;
    status_clr    = '0;
    result_wr     = 1'b0;

    if (wr_en) begin
      if (idx == IDX_STATUS) begin
        // W1C: strobed ones clear the matching status bits.
        status_clr = DATA_W'(apply_wstrb('0, CSR_MAX_W'(req_wdata),
                                         CSR_MAX_B'(req_wstrb)));
      end else if (idx == IDX_RESULT) begin
        if (|req_wstrb) begin
          regs_d[IDX_RESULT] = merged;
          result_wr          = 1'b1;
        end
      end else begin
        regs_d[idx] = merged;
        if (idx == IDX_CTRL) begin
          regs_d[IDX_CTRL][CTRL_GO_BIT] = 1'b0;
          start_pulse_d = req_wstrb[CTRL_GO_BIT/8] && req_wdata[CTRL_GO_BIT];
        end
      end
    end

    // Events are ORed in after the clear so a coincident set wins.
    regs_d[IDX_STATUS] = (regs_q[IDX_STATUS] & ~status_clr) | hw_event;

    // A bus write to the counter in the same cycle swallows the increment.
    if (hw_inc && !result_wr) begin
      regs_d[IDX_RESULT] = regs_q[IDX_RESULT] + DATA_W'(1);
    end
  end

  // Register array and response stage; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q        <= '{default: '0};
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      start_pulse_q <= start_pulse_d;
      if (accept) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= rdata_d;
        resp_err_q   <= !in_range;
      end else if (resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign start_pulse  = start_pulse_q;
  assign status       = regs_q[IDX_STATUS];
  assign result_bytes = regs_q[IDX_RESULT];
  assign irq          = |(regs_q[IDX_STATUS] & regs_q[IDX_IRQ_EN]);

endmodule

// File: tb/tb_ctrl_csr_bank.sv
// Self-checking bench for ctrl_csr_bank: directed vector table, hand-written
// handshake/reset corner sequences, then randomized traffic against a model.
module tb_ctrl_csr_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] hw_event;
  logic        hw_inc;
  logic        start_pulse;
  logic [31:0] status;
  logic [31:0] result_bytes;
  logic        irq;

  int errors = 0;
  int checks = 0;

  ctrl_csr_bank #(.DATA_W(32), .NUM_REGS(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .hw_event(hw_event), .hw_inc(hw_inc), .start_pulse(start_pulse),
    .status(status), .result_bytes(result_bytes), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; resp_ready = 1'b1; hw_event = '0; hw_inc = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One request with resp_ready held high; returns what was seen one cycle later.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] ev, input logic inc,
                      output logic vld, output logic [31:0] rd, output logic er,
                      output logic sp);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    resp_ready = 1'b1; hw_event = ev; hw_inc = inc;
    @(negedge clk);
    vld = resp_valid; rd = resp_rdata; er = resp_err; sp = start_pulse;
    idle_inputs();
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  // Reference model state: registers by index, plus the response slot.
  logic [31:0] m_regs [8];
  logic        m_rv;
  logic [31:0] m_rd;
  logic        m_er;
  logic        m_start;

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [31:0] nxt [8];
    logic [31:0] clr;
    logic        acc;
    logic        inr;
    logic        res_written;
    int          r;
    nxt = m_regs;
    clr = 0;
    res_written = 0;
    acc = req_valid && (!m_rv || resp_ready);
    inr = (req_addr < 8);
    r   = int'(req_addr[2:0]);
    m_start = 0;
    if (acc && inr && req_we) begin
      for (int k = 0; k < 4; k++) begin
        if (req_wstrb[k]) begin
          if (r == 1) clr[8*k +: 8] = req_wdata[8*k +: 8];
          else        nxt[r][8*k +: 8] = req_wdata[8*k +: 8];
        end
      end
      if (r == 0) begin
        nxt[0][0] = 1'b0;
        m_start = req_wstrb[0] && req_wdata[0];
      end
      if (r == 2 && req_wstrb != 0) res_written = 1;
    end
    nxt[1] = (m_regs[1] & ~clr) | hw_event;
    if (hw_inc && !res_written) nxt[2] = m_regs[2] + 1;
    if (acc) begin
      m_rv = 1;
      m_rd = (inr && !req_we) ? m_regs[r] : 0;
      m_er = !inr;
    end else if (resp_ready) begin
      m_rv = 0;
    end
    m_regs = nxt;
  endtask

  initial begin
    logic        v, e, s;
    logic [31:0] d;

    vecs[0]  = '{1'b1, 32'd4,     32'hDEADBEEF, 4'b0101, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'd4,     32'h0,        4'b0000, 32'h00AD00EF, 1'b0};
    vecs[2]  = '{1'b1, 32'd4,     32'h11223344, 4'b1010, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'd4,     32'h0,        4'b0000, 32'h11AD33EF, 1'b0};
    vecs[4]  = '{1'b1, 32'd7,     32'hCAFEF00D, 4'b1111, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'd7,     32'h0,        4'b0000, 32'hCAFEF00D, 1'b0};
    vecs[6]  = '{1'b1, 32'd8,     32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 32'h104,   32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'd4,     32'h0,        4'b0000, 32'h11AD33EF, 1'b0};
    vecs[9]  = '{1'b0, 32'd9,     32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 32'd0,     32'h3,        4'b1111, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'd0,     32'h0,        4'b0000, 32'h2,        1'b0};
    vecs[12] = '{1'b1, 32'd0,     32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'd0,     32'h0,        4'b0000, 32'h2,        1'b0};

    idle_inputs();
    rst = 1'b1;
    do_reset();

    // Reset state.
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_start", start_pulse, 0);
    check("rst_irq", irq, 0);
    check("rst_status", status, 0);
    check("rst_result", result_bytes, 0);
    check("rst_req_ready", req_ready, 1);

    // Eight back-to-back reads: one response per cycle, all zero.
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check($sformatf("b2b%0d_valid", i - 1), resp_valid, 1);
        check($sformatf("b2b%0d_rdata", i - 1), resp_rdata, 0);
        check($sformatf("b2b%0d_err", i - 1), resp_err, 0);
        check($sformatf("b2b%0d_ready", i - 1), req_ready, 1);
      end
      if (i < 8) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = i;
      end else begin
        idle_inputs();
      end
    end

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, 0, v, d, e, s);
      check($sformatf("vec%0d_valid", i), v, 1);
      check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
    end

    // STATUS events, W1C and interrupt masking.
    @(negedge clk); hw_event = 32'h5;
    @(negedge clk); hw_event = 32'h0;
    xact(1, 3, 32'h4, 4'hF, 0, 0, v, d, e, s);
    check("st_set_status", status, 32'h5);
    check("st_set_irq", irq, 1);
    xact(1, 1, 32'h4, 4'hF, 32'h4, 0, v, d, e, s);
    check("st_setwins_status", status, 32'h5);
    check("st_setwins_irq", irq, 1);
    xact(1, 1, 32'h4, 4'hF, 0, 0, v, d, e, s);
    check("st_clear_status", status, 32'h1);
    check("st_clear_irq", irq, 0);

    // RESULT_BYTES wrap and write-over-increment priority.
    xact(1, 2, 32'hFFFFFFFF, 4'hF, 0, 0, v, d, e, s);
    check("res_write", result_bytes, 32'hFFFFFFFF);
    @(negedge clk); hw_inc = 1'b1;
    @(negedge clk); hw_inc = 1'b0;
    check("res_wrap", result_bytes, 32'h0);
    xact(1, 2, 32'h10, 4'hF, 0, 1, v, d, e, s);
    check("res_wr_beats_inc", result_bytes, 32'h10);
    @(negedge clk); hw_inc = 1'b1;
    @(negedge clk); hw_inc = 1'b0;
    check("res_inc", result_bytes, 32'h11);

    // GO pulse: single, then two consecutive writes give two pulses.
    xact(1, 0, 32'h3, 4'hF, 0, 0, v, d, e, s);
    check("go_pulse", s, 1);
    @(negedge clk);
    check("go_pulse_end", start_pulse, 0);
    xact(0, 0, 0, 4'h0, 0, 0, v, d, e, s);
    check("go_readback", d, 32'h2);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 0; req_wdata = 32'h1; req_wstrb = 4'h1;
    @(negedge clk);
    check("go_consec0", start_pulse, 1);
    @(negedge clk);
    idle_inputs();
    check("go_consec1", start_pulse, 1);
    @(negedge clk);
    check("go_consec_end", start_pulse, 0);

    // Out-of-range read stalled by resp_ready low.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_valid", i), resp_valid, 1);
      check($sformatf("stall%0d_err", i), resp_err, 1);
      check($sformatf("stall%0d_rdata", i), resp_rdata, 0);
      check($sformatf("stall%0d_ready", i), req_ready, 0);
      if (i < 2) @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    check("stall_release_ready", req_ready, 1);
    @(negedge clk);
    check("stall_done_valid", resp_valid, 0);

    // Reset coinciding with a write: no response, no effect.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6; req_wdata = 32'hFFFF; req_wstrb = 4'hF;
    rst = 1'b1;
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    check("rstmid_valid", resp_valid, 0);
    xact(0, 6, 0, 4'h0, 0, 0, v, d, e, s);
    check("rstmid_reg6", d, 0);

    // Reset while a response is pending drops it and clears registers.
    xact(1, 4, 32'hA5A5A5A5, 4'hF, 0, 0, v, d, e, s);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("pend_valid", resp_valid, 1);
    check("pend_rdata", resp_rdata, 32'hA5A5A5A5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    check("pend_dropped", resp_valid, 0);
    xact(0, 4, 0, 4'h0, 0, 0, v, d, e, s);
    check("pend_reg4_cleared", d, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
    m_rv = 0; m_rd = 0; m_er = 0; m_start = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      check("rnd_resp_valid", resp_valid, m_rv);
      if (m_rv) begin
        check("rnd_resp_rdata", resp_rdata, m_rd);
        check("rnd_resp_err", resp_err, m_er);
      end
      check("rnd_status", status, m_regs[1]);
      check("rnd_result", result_bytes, m_regs[2]);
      check("rnd_irq", irq, |(m_regs[1] & m_regs[3]));
      check("rnd_start", start_pulse, m_start);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_we     = $urandom_range(0, 1);
      req_addr   = ($urandom_range(0, 15) == 0) ? $urandom() : $urandom_range(0, 10);
      req_wdata  = $urandom();
      req_wstrb  = $urandom_range(0, 15);
      resp_ready = ($urandom_range(0, 3) != 0);
      hw_event   = ($urandom_range(0, 3) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
      hw_inc     = $urandom_range(0, 1);
      #1;
      check("rnd_req_ready", req_ready, !m_rv || resp_ready);
      model_step();
    end
    @(negedge clk);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
